stopwatch_lap_timer: RTL and testbench

Parametrised successor to the single-counter stopwatch: an up/down tick counter with a programmable prescaler, preload, expiry and overflow flags, and a lap-capture FIFO. It sits between the board button/switch decoder, which drives `control`, `lap_stb` and `lap_rd`, and the display/readout logic, which consumes `count` and `lap_data`. One instance serves one timing channel. All state is in the `clk` domain.

---
 rtl/stopwatch_lap_timer.sv | 217 +++++++++++++++++++++
 tb/tb_stopwatch_lap_timer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_timer.sv
// ---------------------------------------------------------------------------
// stopwatch_lap_timer
//
// Up/down tick counter with a programmable prescaler, preload, sticky
// expiry/overflow flags and a small lap-capture FIFO. One instance serves one
// timing channel. Everything runs in the clk domain.
//
// Parameters
//   TICK_DIV  : clocks per count tick (>= 2)
//   CNT_W     : width of count, preload and lap entries
//   LAP_DEPTH : lap FIFO entries (power of two, >= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   control   in   level command: 0 CLEAR, 1 RUN_UP, 2 HOLD, 3 RUN_DOWN,
//                  4 LOAD, 5..7 treated as HOLD
//   load_val  in   preload value used by LOAD
//   lap_stb   in   one-cycle capture of count into the lap FIFO
//   lap_rd    in   one-cycle pop of the lap FIFO head
//   count     out  current tick count (registered)
//   running   out  counting and not expired (decoded from registered state)
//   expired   out  sticky, down-count reached 0 (registered)
//   overflow  out  sticky, up-count wrapped to 0 (registered)
//   lap_data  out  FIFO head, 0 when empty (decoded from registered state)
//   lap_empty out  FIFO empty
//   lap_full  out  FIFO full
//   lap_ovf   out  sticky, a capture was dropped on a full FIFO (registered)
//
// Run-mode FSM (tracks the last sampled command so running has no
// combinational path from control):
//   state   | meaning
//   M_STOP  | CLEAR, LOAD, HOLD or reserved command last sampled
//   M_UP    | RUN_UP last sampled
//   M_DOWN  | RUN_DOWN last sampled
// ---------------------------------------------------------------------------
module stopwatch_lap_timer #(
    parameter int TICK_DIV  = 100000,
    parameter int CNT_W     = 32,
    parameter int LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       control,
    input  logic [CNT_W-1:0] load_val,
    input  logic             lap_stb,
    input  logic             lap_rd,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             overflow,
    output logic [CNT_W-1:0] lap_data,
    output logic             lap_empty,
    output logic             lap_full,
    output logic             lap_ovf
);

    localparam int PW    = $clog2(TICK_DIV);
    localparam int AW    = $clog2(LAP_DEPTH);
    localparam int OCC_W = AW + 1;

    localparam logic [2:0] CMD_CLEAR    = 3'd0;
    localparam logic [2:0] CMD_RUN_UP   = 3'd1;
    localparam logic [2:0] CMD_RUN_DOWN = 3'd3;
    localparam logic [2:0] CMD_LOAD     = 3'd4;

    typedef enum logic [1:0] {
        M_STOP = 2'd0,
        M_UP   = 2'd1,
        M_DOWN = 2'd2
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d, pre_nxt;
    logic             exp_q, exp_d;
    logic             ovf_q, ovf_d;
    logic             lovf_q, lovf_d;
    logic             tick;
    logic             flush;

    logic [CNT_W-1:0] mem_q [LAP_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [OCC_W-1:0] occ_q;
    logic             fifo_empty, fifo_full;
    logic             do_push, do_pop;

    assign tick    = (pre_q == PW'(TICK_DIV - 1));
    assign pre_nxt = tick ? '0 : pre_q + 1'b1;

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_W'(LAP_DEPTH));
    assign do_pop     = lap_rd & ~fifo_empty;
    // A full FIFO still accepts a capture when the same edge frees a slot.
    assign do_push    = lap_stb & (~fifo_full | do_pop);

    // -----------------------------------------------------------------------
    // Next-state logic for counter, prescaler, flags and run mode
    // -----------------------------------------------------------------------
    always_comb begin
        mode_d = M_STOP;
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        exp_d  = exp_q;
        ovf_d  = ovf_q;
        lovf_d = lovf_q;
        flush  = 1'b0;

        if (lap_stb && fifo_full && !lap_rd) begin
            lovf_d = 1'b1;
        end

        case (control)
            CMD_CLEAR: begin
                cnt_d  = '0;
                pre_d  = '0;
                exp_d  = 1'b0;
                ovf_d  = 1'b0;
                lovf_d = 1'b0;
                flush  = 1'b1;
            end
            CMD_LOAD: begin
                cnt_d = load_val;
                pre_d = '0;
                exp_d = 1'b0;
                ovf_d = 1'b0;
            end
            CMD_RUN_UP: begin
                mode_d = M_UP;
                pre_d  = pre_nxt;
                if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            CMD_RUN_DOWN: begin
                mode_d = M_DOWN;
                // Once expired, the down-counter parks at 0 with the
                // prescaler frozen; only CLEAR/LOAD release it.
                if (!exp_q) begin
                    pre_d = pre_nxt;
                    if (tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d = '0;
                            exp_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_STOP;
            cnt_q  <= '0;
            pre_q  <= '0;
            exp_q  <= 1'b0;
            ovf_q  <= 1'b0;
            lovf_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            exp_q  <= exp_d;
            ovf_q  <= ovf_d;
            lovf_q <= lovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Lap FIFO; captures the count value from before this edge's update
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= cnt_q;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign count     = cnt_q;
    assign running   = ((mode_q == M_UP) || (mode_q == M_DOWN)) && !exp_q;
    assign expired   = exp_q;
    assign overflow  = ovf_q;
    assign lap_ovf   = lovf_q;
    assign lap_empty = fifo_empty;
    assign lap_full  = fifo_full;
    assign lap_data  = fifo_empty ? '0 : mem_q[rd_q];

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
module tb_stopwatch_lap_timer;

    localparam int CW = 8;

    localparam int S_CNT  = 0;
    localparam int S_RUN  = 1;
    localparam int S_EXP  = 2;
    localparam int S_OVF  = 3;
    localparam int S_DATA = 4;
    localparam int S_EMP  = 5;
    localparam int S_FULL = 6;
    localparam int S_LOVF = 7;

    localparam logic [2:0] C_CLEAR = 3'd0;
    localparam logic [2:0] C_UP    = 3'd1;
    localparam logic [2:0] C_HOLD  = 3'd2;
    localparam logic [2:0] C_DOWN  = 3'd3;
    localparam logic [2:0] C_LOAD  = 3'd4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [2:0]    control;
    logic [CW-1:0] load_val;
    logic          lap_stb;
    logic          lap_rd;
    logic [CW-1:0] count;
    logic          running;
    logic          expired;
    logic          overflow;
    logic [CW-1:0] lap_data;
    logic          lap_empty;
    logic          lap_full;
    logic          lap_ovf;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    stopwatch_lap_timer #(
        .TICK_DIV (4),
        .CNT_W    (CW),
        .LAP_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .control  (control),
        .load_val (load_val),
        .lap_stb  (lap_stb),
        .lap_rd   (lap_rd),
        .count    (count),
        .running  (running),
        .expired  (expired),
        .overflow (overflow),
        .lap_data (lap_data),
        .lap_empty(lap_empty),
        .lap_full (lap_full),
        .lap_ovf  (lap_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            S_CNT:   return {24'd0, count};
            S_RUN:   return {31'd0, running};
            S_EXP:   return {31'd0, expired};
            S_OVF:   return {31'd0, overflow};
            S_DATA:  return {24'd0, lap_data};
            S_EMP:   return {31'd0, lap_empty};
            S_FULL:  return {31'd0, lap_full};
            default: return {31'd0, lap_ovf};
        endcase
    endfunction

    // Monitor: outputs are level signals, so the DUT "presents" its state
    // every cycle; pending expectations are checked on the falling edge.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sbq.pop_front();
            a = actual(e.sel);
            total++;
            if (a !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h at %0t", e.name, a, e.val, $time);
            end
        end
    end

    task automatic chk(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        control  = C_CLEAR;
        load_val = '0;
        lap_stb  = 1'b0;
        lap_rd   = 1'b0;
        #2 rst_n = 1'b0;
        cyc(2);
        chk("rst_count", S_CNT, 0);
        chk("rst_running", S_RUN, 0);
        chk("rst_expired", S_EXP, 0);
        chk("rst_overflow", S_OVF, 0);
        chk("rst_lap_empty", S_EMP, 1);
        chk("rst_lap_data", S_DATA, 0);
        chk("rst_lap_full", S_FULL, 0);
        chk("rst_lap_ovf", S_LOVF, 0);
        cyc(1);
        rst_n = 1'b1;

        // 1: run up, hold, resume
        control = C_CLEAR; cyc(2);
        control = C_UP;    cyc(40);
        chk("up40_count", S_CNT, 10);
        chk("up40_running", S_RUN, 1);
        control = C_HOLD;  cyc(20);
        chk("hold_count", S_CNT, 10);
        chk("hold_running", S_RUN, 0);
        control = C_UP;    cyc(4);
        chk("resume_count", S_CNT, 11);

        // 2: load and count down to expiry
        control = C_LOAD; load_val = 8'd3; cyc(1);
        chk("load3_count", S_CNT, 3);
        control = C_DOWN; cyc(4);
        chk("down_count2", S_CNT, 2);
        chk("down_running", S_RUN, 1);
        chk("down_exp0", S_EXP, 0);
        cyc(4);
        chk("down_count1", S_CNT, 1);
        cyc(4);
        chk("down_count0", S_CNT, 0);
        chk("down_expired", S_EXP, 1);
        chk("down_exp_running", S_RUN, 0);
        cyc(20);
        chk("down_stay0", S_CNT, 0);
        chk("down_stay_exp", S_EXP, 1);
        control = C_LOAD; load_val = 8'd5; cyc(1);
        chk("load5_count", S_CNT, 5);
        chk("load5_expired", S_EXP, 0);

        // 3: up-count wrap
        control = C_LOAD; load_val = 8'hFE; cyc(1);
        control = C_UP; cyc(4);
        chk("wrap_ff", S_CNT, 8'hFF);
        chk("wrap_ovf0", S_OVF, 0);
        cyc(4);
        chk("wrap_00", S_CNT, 0);
        chk("wrap_ovf1", S_OVF, 1);
        control = C_CLEAR; cyc(1);
        chk("clr_ovf", S_OVF, 0);

        // 4: lap captures at 1..5 with overflow on the fifth
        control = C_UP; cyc(4);
        for (int k = 1; k <= 5; k++) begin
            lap_stb = 1'b1; cyc(1);
            lap_stb = 1'b0; cyc(3);
        end
        control = C_HOLD;
        chk("lap_full", S_FULL, 1);
        chk("lap_ovf_set", S_LOVF, 1);
        chk("lap_count6", S_CNT, 6);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lap_pop%0d", k), S_DATA, k);
            lap_rd = 1'b1; cyc(1);
            lap_rd = 1'b0;
        end
        chk("lap_drained_empty", S_EMP, 1);
        chk("lap_drained_data", S_DATA, 0);
        chk("lap_drained_full", S_FULL, 0);

        // 5: simultaneous push/pop when full and when empty
        control = C_CLEAR; cyc(1);
        chk("clr_lap_ovf", S_LOVF, 0);
        control = C_LOAD; lap_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_val = 8'(10 + i); cyc(1);
        end
        chk("fill_full", S_FULL, 1);
        chk("fill_head", S_DATA, 0);
        chk("fill_count", S_CNT, 13);
        control = C_HOLD; lap_rd = 1'b1; cyc(1);
        lap_stb = 1'b0; lap_rd = 1'b0;
        chk("both_full_full", S_FULL, 1);
        chk("both_full_lovf", S_LOVF, 0);
        chk("both_full_head", S_DATA, 10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("both_pop%0d", k), S_DATA, 10 + k);
            lap_rd = 1'b1; cyc(1);
            lap_rd = 1'b0;
        end
        chk("both_drained", S_EMP, 1);
        lap_stb = 1'b1; lap_rd = 1'b1; cyc(1);
        lap_stb = 1'b0; lap_rd = 1'b0;
        chk("both_empty_emp", S_EMP, 0);
        chk("both_empty_data", S_DATA, 13);
        lap_rd = 1'b1; cyc(1);
        lap_rd = 1'b0;
        chk("both_empty_one", S_EMP, 1);
        control = C_CLEAR; lap_stb = 1'b1; cyc(1);
        lap_stb = 1'b0;
        chk("clear_stb_discard", S_EMP, 1);

        // 6: async reset mid run-down
        control = C_LOAD; load_val = 8'd9; cyc(1);
        control = C_HOLD; lap_stb = 1'b1; cyc(2);
        lap_stb = 1'b0;
        control = C_DOWN; cyc(8);
        chk("pre_rst_count", S_CNT, 7);
        chk("pre_rst_data", S_DATA, 9);
        cyc(2);
        rst_n = 1'b0;
        chk("arst_count", S_CNT, 0);
        chk("arst_empty", S_EMP, 1);
        chk("arst_running", S_RUN, 0);
        chk("arst_lovf", S_LOVF, 0);
        control = C_UP;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        chk("rel_count0", S_CNT, 0);
        cyc(1);
        chk("rel_count1", S_CNT, 1);

        cyc(2);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
